// File: rtl/mul4_fitness_scorer.sv
// Scores candidate 2x2-bit multiplier outputs across 16 bit-sliced lanes.
// Two-stage pipeline: per-beat mismatch reduction, then saturating accumulation.
module mul4_fitness_scorer #(
  parameter int NUM_VECTORS = 1,
  parameter int ACC_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a1,
  input  logic [15:0]      a0,
  input  logic [15:0]      b1,
  input  logic [15:0]      b0,
  input  logic [15:0]      y3,
  input  logic [15:0]      y2,
  input  logic [15:0]      y1,
  input  logic [15:0]      y0,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] err_bits,
  output logic [ACC_W-1:0] pass_lanes,
  output logic             perfect
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sum width wide enough for either operand plus a carry.
  localparam int SW = ((ACC_W > 7) ? ACC_W : 7) + 1;
  localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});
  localparam logic [7:0] LAST_BEAT = 8'(NUM_VECTORS - 1);

  state_t state;
  logic [7:0] beat_cnt;

  logic       s1_valid;
  logic [6:0] s1_err;
  logic [4:0] s1_pass;

  logic       accept;
  logic [6:0] beat_err;
  logic [4:0] beat_pass;

  logic [SW-1:0]    err_sum;
  logic [SW-1:0]    pass_sum;
  logic [ACC_W-1:0] err_next;
  logic [ACC_W-1:0] pass_next;

  function automatic logic [3:0] lane_prod(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [3:0] p;
    p = {2'b00, a} * {2'b00, b};
    return p;
  endfunction

  function automatic logic [2:0] pop4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    return n;
  endfunction

  assign accept   = (state == RUN) && in_valid;
  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  always_comb begin
    logic [3:0] diff;
    beat_err  = '0;
    beat_pass = '0;
    diff      = '0;
    for (int i = 0; i < 16; i++) begin
      diff = lane_prod({a1[i], a0[i]}, {b1[i], b0[i]})
           ^ {y3[i], y2[i], y1[i], y0[i]};
      beat_err = beat_err + 7'(pop4(diff));
      if (diff == 4'd0) begin
        beat_pass = beat_pass + 5'd1;
      end
    end
  end

  // Saturating accumulate of the registered stage-1 counts.
  always_comb begin
    err_sum   = SW'(err_bits) + SW'(s1_err);
    pass_sum  = SW'(pass_lanes) + SW'(s1_pass);
    err_next  = err_bits;
    pass_next = pass_lanes;
    if (s1_valid) begin
      err_next  = (err_sum > ACC_MAX) ? '1 : err_sum[ACC_W-1:0];
      pass_next = (pass_sum > ACC_MAX) ? '1 : pass_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      s1_valid   <= 1'b0;
      s1_err     <= '0;
      s1_pass    <= '0;
      err_bits   <= '0;
      pass_lanes <= '0;
      perfect    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_err  <= beat_err;
        s1_pass <= beat_pass;
      end
      err_bits   <= err_next;
      pass_lanes <= pass_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            err_bits   <= '0;
            pass_lanes <= '0;
            perfect    <= 1'b0;
            beat_cnt   <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt == LAST_BEAT) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Last beat lands in the accumulator on this edge.
          perfect <= (err_next == '0);
          state   <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Directed bench for mul4_fitness_scorer across three parameterisations.
// Inputs change and outputs are sampled on the falling edge.
module tb_mul4_fitness_scorer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid;
  logic start1, start4, start2;
  logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;

  logic rdy1, busy1, done1, perf1;
  logic [15:0] err1, pass1;
  logic rdy4, busy4, done4, perf4;
  logic [15:0] err4, pass4;
  logic rdy2, busy2, done2, perf2;
  logic [5:0] err2, pass2;

  int checks = 0;
  int failures = 0;

  mul4_fitness_scorer #(.NUM_VECTORS(1), .ACC_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid),
    .in_ready(rdy1), .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0), .busy(busy1), .done(done1),
    .err_bits(err1), .pass_lanes(pass1), .perfect(perf1));

  mul4_fitness_scorer #(.NUM_VECTORS(4), .ACC_W(16)) u4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid),
    .in_ready(rdy4), .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0), .busy(busy4), .done(done4),
    .err_bits(err4), .pass_lanes(pass4), .perfect(perf4));

  mul4_fitness_scorer #(.NUM_VECTORS(2), .ACC_W(6)) u2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid),
    .in_ready(rdy2), .a1(a1), .a0(a0), .b1(b1), .b0(b0),
    .y3(y3), .y2(y2), .y1(y1), .y0(y0), .busy(busy2), .done(done2),
    .err_bits(err2), .pass_lanes(pass2), .perfect(perf2));

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Lane i has A=i[3:2], B=i[1:0]: all 16 operand pairs.
  task automatic ops_all();
    a1 = 16'hFF00; a0 = 16'hF0F0; b1 = 16'hCCCC; b0 = 16'hAAAA;
  endtask

  task automatic y_golden();
    y3 = 16'h8000; y2 = 16'h4C00; y1 = 16'h6AC0; y0 = 16'hA0A0;
  endtask

  task automatic y_zero();
    y3 = 16'h0; y2 = 16'h0; y1 = 16'h0; y0 = 16'h0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    start1 = 1'b0; start4 = 1'b0; start2 = 1'b0;
    ops_all(); y_zero();
    step(); step();
    rst = 1'b0;
    step();
    check("rst_ready", {29'd0, rdy1, rdy4, rdy2}, 32'd0);
    check("rst_busy", {29'd0, busy1, busy4, busy2}, 32'd0);
    check("rst_done", {29'd0, done1, done4, done2}, 32'd0);
    check("rst_err", 32'(err1) + 32'(err4) + 32'(err2), 32'd0);
    check("rst_pass", 32'(pass1) + 32'(pass4) + 32'(pass2), 32'd0);
    check("rst_perfect", {29'd0, perf1, perf4, perf2}, 32'd0);

    // Exhaustive-correct single beat.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("run_ready", {31'd0, rdy1}, 32'd1);
    check("run_busy", {31'd0, busy1}, 32'd1);
    in_valid = 1'b1; y_golden();
    step();
    in_valid = 1'b0;
    check("drain_state", {29'd0, busy1, rdy1, done1}, 32'b100);
    step();
    check("gold_done", {30'd0, done1, busy1}, 32'b10);
    check("gold_err", 32'(err1), 32'd0);
    check("gold_pass", 32'(pass1), 32'd16);
    check("gold_perfect", {31'd0, perf1}, 32'd1);
    step();
    check("gold_done_pulse", {31'd0, done1}, 32'd0);
    check("gold_hold", 32'(pass1), 32'd16);
    check("gold_hold_perf", {31'd0, perf1}, 32'd1);

    // Zero candidate.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("zero_start_clr", 32'(pass1), 32'd0);
    in_valid = 1'b1; y_zero();
    step();
    in_valid = 1'b0;
    step();
    check("zero_done", {31'd0, done1}, 32'd1);
    check("zero_err", 32'(err1), 32'd14);
    check("zero_pass", 32'(pass1), 32'd7);
    check("zero_perfect", {31'd0, perf1}, 32'd0);
    step();

    // All-ones candidate against zero operands.
    a1 = 16'h0; a0 = 16'h0; b1 = 16'h0; b0 = 16'h0;
    y3 = 16'hFFFF; y2 = 16'hFFFF; y1 = 16'hFFFF; y0 = 16'hFFFF;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("ones_err", 32'(err1), 32'd64);
    check("ones_pass", 32'(pass1), 32'd0);
    step();

    // Saturation with a 6-bit accumulator over two beats.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check("sat_mid_err", 32'(err2), 32'd63);
    check("sat_drain", {30'd0, busy2, done2}, 32'b10);
    step();
    check("sat_done", {31'd0, done2}, 32'd1);
    check("sat_err", 32'(err2), 32'd63);
    check("sat_pass", 32'(pass2), 32'd0);
    check("sat_perfect", {31'd0, perf2}, 32'd0);
    step();

    // Four beats with gaps, plus start in RUN and in_valid in DRAIN.
    ops_all(); y_zero();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k % 2 == 0);
      start4 = (k == 1);
      step();
      if (k < 6) check($sformatf("gap_busy%0d", k), {30'd0, busy4, done4}, 32'b10);
    end
    start4 = 1'b0;
    check("gap_drain", {29'd0, busy4, rdy4, done4}, 32'b100);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("gap_done", {30'd0, done4, busy4}, 32'b10);
    check("gap_err", 32'(err4), 32'd56);
    check("gap_pass", 32'(pass4), 32'd28);
    check("gap_perfect", {31'd0, perf4}, 32'd0);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check("idle_valid_ignored", 32'(err4), 32'd56);
    check("idle_ready", {30'd0, rdy4, busy4}, 32'd0);

    // Reset after two of four beats, with start/in_valid colliding.
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    rst = 1'b1; start4 = 1'b1;
    step();
    rst = 1'b0; start4 = 1'b0; in_valid = 1'b0;
    check("abort_state", {29'd0, rdy4, busy4, done4}, 32'd0);
    check("abort_err", 32'(err4), 32'd0);
    check("abort_pass", 32'(pass4), 32'd0);
    begin
      int seen = 0;
      for (int k = 0; k < 6; k++) begin
        if (done4) seen++;
        step();
      end
      check("abort_no_done", 32'(seen), 32'd0);
    end
    y_golden();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    in_valid = 1'b1;
    repeat (4) step();
    in_valid = 1'b0;
    step();
    check("fresh_done", {31'd0, done4}, 32'd1);
    check("fresh_err", 32'(err4), 32'd0);
    check("fresh_pass", 32'(pass4), 32'd64);
    check("fresh_perfect", {31'd0, perf4}, 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul4_fitness_scorer.md
MUL4_FITNESS_SCORER -- requirements
Module: mul4_fitness_scorer

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 1, meaning the number of accepted input beats per evaluation run (legal values 1..255).
REQ-002 SHALL have parameter ACC_W, default 16, meaning the width of the err_bits and pass_lanes accumulators.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begins a run when sampled high in IDLE.
REQ-006 SHALL have port in_valid  input  1  the current beat's a*/y* vectors are valid.
REQ-007 SHALL have port in_ready  output  1  the scorer accepts a beat this cycle.
REQ-008 SHALL have ports a1, a0, b1, b0  input  16 each  bit-sliced 2-bit operands; lane i operand A={a1[i],a0[i]}, B={b1[i],b0[i]}.
REQ-009 SHALL have ports y3, y2, y1, y0  input  16 each  candidate 4-bit product per lane, Y={y3[i],y2[i],y1[i],y0[i]}.
REQ-010 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking final results.
REQ-012 SHALL have port err_bits  output  ACC_W  accumulated count of wrong product bits.
REQ-013 SHALL have port pass_lanes  output  ACC_W  accumulated count of lanes with a fully correct product.
REQ-014 SHALL have port perfect  output  1  err_bits==0 for the completed run.

Function
REQ-015 SHALL implement the FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-016 In IDLE, start=1 SHALL clear err_bits, pass_lanes, perfect and the beat counter and move to RUN; in_ready=0 in IDLE.
REQ-017 In RUN, in_ready=1; a beat SHALL be accepted in any cycle with in_valid=1 and in_ready=1; in_valid=0 cycles SHALL NOT advance the beat counter.
REQ-018 Stage 1 SHALL, per accepted beat, compute per lane golden P=A*B (4 bits, unsigned), mismatch count popcount(P xor Y) summed over 16 lanes (0..64), and lane-pass count (lanes with P==Y, 0..16), and register them with a valid flag.
REQ-019 Stage 2 SHALL add the stage-1 values into err_bits and pass_lanes in the cycle after acceptance; each accumulator SHALL saturate at 2^ACC_W-1 rather than wrap.
REQ-020 On acceptance of beat NUM_VECTORS (cycle C), the FSM SHALL be in DRAIN during C+1 (in_ready=0) and in DONE during C+2.
REQ-021 In DONE, done=1 for exactly one cycle, err_bits/pass_lanes are final, and perfect=(err_bits==0); the FSM returns to IDLE on the next edge.
REQ-022 err_bits, pass_lanes and perfect SHALL hold their values after DONE until the next accepted start or reset.
REQ-023 start SHALL be ignored in RUN, DRAIN and DONE; in_valid SHALL be ignored outside RUN.
REQ-024 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, clear the stage-1 valid flag and beat counter, and drive in_ready=0, busy=0, done=0, err_bits=0, pass_lanes=0, perfect=0 from the following cycle.
REQ-026 rst asserted mid-run SHALL discard all partial results; no done pulse SHALL be produced for the aborted run.
REQ-027 rst SHALL take priority over start and in_valid in the same cycle.

Verification
REQ-028 Exhaustive-correct: a1=FF00, a0=F0F0, b1=CCCC, b0=AAAA, y* = golden products, NUM_VECTORS=1 -> done in C+2, err_bits=0, pass_lanes=16, perfect=1.
REQ-029 Zero candidate: same a*/b*, y3..y0=0000 -> err_bits=14, pass_lanes=7, perfect=0.
REQ-030 All-ones candidate: a*/b*=0000, y3..y0=FFFF -> err_bits=64, pass_lanes=0; with ACC_W=6, two such beats (NUM_VECTORS=2) -> err_bits=63 (saturated).
REQ-031 NUM_VECTORS=4, scenario REQ-029 beats with in_valid low on alternate cycles -> exactly 4 beats counted, err_bits=56, pass_lanes=28, done 2 cycles after 4th acceptance.
REQ-032 Reset mid-run: rst after 2 of 4 beats -> all outputs 0, IDLE next cycle, no done; fresh start then yields clean results.
REQ-033 Protocol: start pulsed in RUN and in_valid pulsed in IDLE/DRAIN -> no restart, no extra beats counted, results unchanged.
